ttl_gate_array_inertial: RTL

- Parametrised, clocked successor to the fixed TTL gate-package models in the hw_sim library.
- Provides CHANNELS independent gates, each with INPUTS inputs and a selectable logic function.
- Each output follows its gate result only after the result has been stable for DELAY clocks (inertial delay), so it models TTL propagation and pulse rejection.
- Every rejected pulse is flagged per channel; board-level sims use the flags to find decode glitches.

---
 rtl/ttl_gate_array_inertial_if.sv | 14 +
 rtl/ttl_gate_array_inertial.sv | 111 +++++++++++
 2 files changed

// File: rtl/ttl_gate_array_inertial_if.sv
// Gate-array bus: enable, gate inputs and flag clear in; delayed outputs and glitch flags out.
interface ttl_gate_array_inertial_if #(
  parameter int CHANNELS = 3,
  parameter int INPUTS   = 3
);
  logic                         en;
  logic [CHANNELS*INPUTS-1:0]   in;
  logic                         glitch_clr;
  logic [CHANNELS-1:0]          out;
  logic [CHANNELS-1:0]          glitch;

  modport master (output en, in, glitch_clr, input out, glitch);
  modport slave  (input en, in, glitch_clr, output out, glitch);
endinterface

// File: rtl/ttl_gate_array_inertial.sv
// Array of logic gates whose outputs follow the gate result after DELAY stable clocks, rejecting shorter pulses.
// Latency: DELAY enabled edges; no backpressure, en=0 freezes every channel.
module ttl_gate_array_inertial #(
  parameter int CHANNELS = 3,
  parameter int INPUTS   = 3,
  parameter int FUNC     = 0,
  parameter int DELAY    = 2
) (
  input logic                    clk,
  input logic                    rst,
  ttl_gate_array_inertial_if.slave bus
);
  localparam int            CW       = $clog2(DELAY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DELAY - 1);
  // Output value of the gate with all inputs low.
  localparam logic          RST_OUT  = (FUNC == 1) || (FUNC == 3) || (FUNC == 5);

  typedef enum logic {STABLE, PENDING} state_t;

  state_t              state_q [CHANNELS];
  state_t              state_d [CHANNELS];
  logic [CW-1:0]       cnt_q   [CHANNELS];
  logic [CW-1:0]       cnt_d   [CHANNELS];
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_d;
  logic [CHANNELS-1:0] glitch_q;
  logic [CHANNELS-1:0] glitch_set;
  logic [CHANNELS-1:0] tgt;

  function automatic logic gate_f(input logic [INPUTS-1:0] v);
    logic r;
    case (FUNC)
      1:       r = ~&v;
      2:       r = |v;
      3:       r = ~|v;
      4:       r = ^v;
      5:       r = ~^v;
      default: r = &v;
    endcase
    return r;
  endfunction

  always_comb begin
    tgt = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      tgt[c] = gate_f(bus.in[c*INPUTS +: INPUTS]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= STABLE;
        cnt_q[c]   <= '0;
      end
      out_q    <= {CHANNELS{RST_OUT}};
      glitch_q <= '0;
    end else begin
      if (bus.en) begin
        for (int c = 0; c < CHANNELS; c++) begin
          state_q[c] <= state_d[c];
          cnt_q[c]   <= cnt_d[c];
        end
        out_q <= out_d;
      end
      // A new glitch on the same edge as a clear keeps the flag set.
      glitch_q <= (bus.glitch_clr ? '0 : glitch_q) | (bus.en ? glitch_set : '0);
    end
  end

  always_comb begin
    out_d      = out_q;
    glitch_set = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        STABLE: begin
          if (tgt[c] != out_q[c]) begin
            if (DELAY == 1) begin
              out_d[c] = tgt[c];
            end else begin
              state_d[c] = PENDING;
              cnt_d[c]   = CW'(1);
            end
          end else begin
            cnt_d[c] = '0;
          end
        end
        default: begin
          if (tgt[c] == out_q[c]) begin
            state_d[c]    = STABLE;
            cnt_d[c]      = '0;
            glitch_set[c] = 1'b1;
          end else if (cnt_q[c] == CNT_LAST) begin
            out_d[c]   = tgt[c];
            state_d[c] = STABLE;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CW'(1);
          end
        end
      endcase
    end
  end

  always_comb begin
    bus.out    = out_q;
    bus.glitch = glitch_q;
  end
endmodule
